sdspi_bus_arbiter: RTL and testbench

SDSPI_BUS_ARBITER -- requirements
Module: sdspi_bus_arbiter

---
 rtl/sdspi_arb_pkg.sv | 19 +
 rtl/sdspi_bus_arbiter_if.sv | 30 +++
 rtl/sdspi_arb_timer.sv | 27 ++
 rtl/sdspi_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_sdspi_bus_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdspi_arb_pkg.sv
// Shared types and constants for the SD-card SPI bus arbiter.
package sdspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_U = 2'd2,
    GUARD = 2'd3
  } arb_state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_U = 1'b1;

  // Levels the SD card sees whenever nobody owns the bus
  localparam logic IDLE_CS   = 1'b1;
  localparam logic IDLE_SCLK = 1'b0;
  localparam logic IDLE_MOSI = 1'b1;

endpackage

// File: rtl/sdspi_bus_arbiter_if.sv
// Requester/arbiter bundle: level requests, per-requester SPI drive, grants and the muxed SPI bus.
interface sdspi_bus_arbiter_if;

  logic req_a;
  logic req_u;
  logic cs_a;
  logic sclk_a;
  logic mosi_a;
  logic cs_u;
  logic sclk_u;
  logic mosi_u;
  logic grant_a;
  logic grant_u;
  logic cs;
  logic sclk;
  logic mosi;
  logic bus_sel;

  // master = requester side, slave = arbiter side
  modport master (
    output req_a, req_u, cs_a, sclk_a, mosi_a, cs_u, sclk_u, mosi_u,
    input  grant_a, grant_u, cs, sclk, mosi, bus_sel
  );

  modport slave (
    input  req_a, req_u, cs_a, sclk_a, mosi_a, cs_u, sclk_u, mosi_u,
    output grant_a, grant_u, cs, sclk, mosi, bus_sel
  );

endinterface

// File: rtl/sdspi_arb_timer.sv
// Loadable down-counter; term flags the last counted cycle (count == 1).
module sdspi_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         term
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign term = (count == W'(1));

endmodule

// File: rtl/sdspi_bus_arbiter.sv
// Two-requester SD-card SPI bus arbiter with round-robin, guard gap and optional
// ownership timeout (enabled by defining SDSPI_ARB_TIMEOUT_EN).
module sdspi_bus_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 16,
  parameter int TIMEOUT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sdspi_bus_arbiter_if.slave   bus,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 timeout_err,
  output logic                 timeout_sticky
);

  arb_state_t state;
  logic       grant_a_q;
  logic       grant_u_q;
  logic       bus_sel_q;
  logic       last_owner;
  logic       eff_req_a;
  logic       eff_req_u;
  logic       revoke;
  logic       guard_load;
  logic       guard_term;

`ifdef SDSPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 owning;
  logic                 blocked_a;
  logic                 blocked_u;
  logic                 err_q;
  logic                 sticky_q;

  assign owning = (state == OWN_A) || (state == OWN_U);

  // to_cnt + 1 is the number of cycles owned including the current one
  assign revoke = owning && (timeout_cycles != '0) &&
                  ((to_cnt + TIMEOUT_W'(1)) == timeout_cycles) &&
                  ((state == OWN_A) ? bus.req_a : bus.req_u);

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt    <= '0;
      blocked_a <= 1'b0;
      blocked_u <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      to_cnt <= owning ? to_cnt + TIMEOUT_W'(1) : '0;
      err_q  <= revoke;
      if (revoke) sticky_q <= 1'b1;
      if (revoke && (state == OWN_A)) blocked_a <= 1'b1;
      else if (!bus.req_a)            blocked_a <= 1'b0;
      if (revoke && (state == OWN_U)) blocked_u <= 1'b1;
      else if (!bus.req_u)            blocked_u <= 1'b0;
    end
  end

  assign eff_req_a      = bus.req_a && !blocked_a;
  assign eff_req_u      = bus.req_u && !blocked_u;
  assign timeout_err    = err_q;
  assign timeout_sticky = sticky_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_cycles;
  assign revoke         = 1'b0;
  assign eff_req_a      = bus.req_a;
  assign eff_req_u      = bus.req_u;
  assign timeout_err    = 1'b0;
  assign timeout_sticky = 1'b0;
`endif

  assign guard_load = ((state == OWN_A) && (!bus.req_a || revoke)) ||
                      ((state == OWN_U) && (!bus.req_u || revoke));

  sdspi_arb_timer #(.W(8)) u_guard_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (guard_load),
    .load_val (8'(GUARD_CYCLES)),
    .dec      (state == GUARD),
    .term     (guard_term)
  );

  // last_owner resets to U so the first contended arbitration goes to A
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant_a_q  <= 1'b0;
      grant_u_q  <= 1'b0;
      bus_sel_q  <= OWNER_A;
      last_owner <= OWNER_U;
    end else begin
      case (state)
        IDLE: begin
          if (eff_req_a && (!eff_req_u || (last_owner == OWNER_U))) begin
            state      <= OWN_A;
            grant_a_q  <= 1'b1;
            bus_sel_q  <= OWNER_A;
            last_owner <= OWNER_A;
          end else if (eff_req_u) begin
            state      <= OWN_U;
            grant_u_q  <= 1'b1;
            bus_sel_q  <= OWNER_U;
            last_owner <= OWNER_U;
          end
        end
        OWN_A: begin
          if (guard_load) begin
            state     <= GUARD;
            grant_a_q <= 1'b0;
          end
        end
        OWN_U: begin
          if (guard_load) begin
            state     <= GUARD;
            grant_u_q <= 1'b0;
          end
        end
        GUARD: begin
          if (guard_term) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          grant_a_q <= 1'b0;
          grant_u_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_a = grant_a_q;
  assign bus.grant_u = grant_u_q;
  assign bus.bus_sel = bus_sel_q;
  assign bus.cs      = grant_a_q ? bus.cs_a   : (grant_u_q ? bus.cs_u   : IDLE_CS);
  assign bus.sclk    = grant_a_q ? bus.sclk_a : (grant_u_q ? bus.sclk_u : IDLE_SCLK);
  assign bus.mosi    = grant_a_q ? bus.mosi_a : (grant_u_q ? bus.mosi_u : IDLE_MOSI);

endmodule

// File: tb/tb_sdspi_bus_arbiter.sv
// Directed self-checking bench for sdspi_bus_arbiter (GUARD_CYCLES = 16).
module tb_sdspi_bus_arbiter;

  localparam int GUARD = 16;
  localparam int TW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [TW-1:0] timeout_cycles;
  logic          timeout_err;
  logic          timeout_sticky;
  int            tests_run    = 0;
  int            tests_failed = 0;

  sdspi_bus_arbiter_if bus_if ();

  sdspi_bus_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_W(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .timeout_cycles (timeout_cycles),
    .timeout_err    (timeout_err),
    .timeout_sticky (timeout_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ra, input logic ru);
    bus_if.req_a = ra;
    bus_if.req_u = ru;
  endtask

  task automatic driveSpi(input logic [2:0] a, input logic [2:0] u);
    {bus_if.cs_a, bus_if.sclk_a, bus_if.mosi_a} = a;
    {bus_if.cs_u, bus_if.sclk_u, bus_if.mosi_u} = u;
  endtask

  function automatic logic [2:0] bus3();
    return {bus_if.cs, bus_if.sclk, bus_if.mosi};
  endfunction

  // Edges until the wanted grant is seen; bad counts non-idle bus cycles while waiting
  task automatic waitGrant(input bit want_u, input int limit, output int edges, output int bad);
    logic got;
    edges = 0;
    bad   = 0;
    got   = 1'b0;
    while (!got && edges < limit) begin
      stepCycle();
      edges++;
      got = want_u ? bus_if.grant_u : bus_if.grant_a;
      if (!got && (bus_if.grant_a || bus_if.grant_u || bus3() !== 3'b101)) bad++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] pats [4];
    int edges, bad, owned, pulses, regrant, lost;
    logic err_at_fall;

    pats = '{3'b000, 3'b011, 3'b101, 3'b110};
    timeout_cycles = '0;
    applyStimulus(1'b0, 1'b0);
    driveSpi(3'b111, 3'b111);

    rst = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rst_grant_a", bus_if.grant_a, 0);
    checkOutput("rst_grant_u", bus_if.grant_u, 0);
    checkOutput("rst_bus_sel", bus_if.bus_sel, 0);
    checkOutput("rst_bus_levels", bus3(), 3'b101);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_timeout_sticky", timeout_sticky, 0);

    // Single request from A: one-cycle grant latency, bus follows A only
    rst = 1'b1;
    repeat (4) stepCycle();
    applyStimulus(1'b1, 1'b0);
    driveSpi(3'b010, 3'b101);
    #1;
    checkOutput("a_grant_same_cycle", bus_if.grant_a, 0);
    stepCycle();
    checkOutput("a_grant", bus_if.grant_a, 1);
    checkOutput("a_grant_u_low", bus_if.grant_u, 0);
    checkOutput("a_bus_sel", bus_if.bus_sel, 0);
    checkOutput("a_bus_first", bus3(), 3'b010);
    foreach (pats[i]) begin
      driveSpi(pats[i], ~pats[i]);
      #1;
      checkOutput("a_bus_follow", bus3(), pats[i]);
    end

    // A releases; U requests two cycles into GUARD and must wait for it to end
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    checkOutput("a_release_grant", bus_if.grant_a, 0);
    checkOutput("guard_bus_levels", bus3(), 3'b101);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    waitGrant(1'b1, 40, edges, bad);
    // GUARD entered at edge 0, IDLE at edge 16, OWN_U at edge 17; waiting began after edge 2
    checkOutput("guard_wait_edges", edges, 15);
    checkOutput("guard_wait_idle_bus", bad, 0);
    checkOutput("u_bus_sel", bus_if.bus_sel, 1);
    driveSpi(3'b111, 3'b001);
    #1;
    checkOutput("u_bus_follow", bus3(), 3'b001);

    // Timeout disabled: long ownership never revoked
    timeout_cycles = '0;
    lost = 0;
    repeat (10000) begin
      stepCycle();
      if (!bus_if.grant_u || timeout_err) lost++;
    end
    checkOutput("no_timeout_long_hold", lost, 0);

    // Reset during OWN_U: immediate idle, then a fresh request needs no guard
    rst = 1'b0;
    stepCycle();
    checkOutput("midrst_grant_u", bus_if.grant_u, 0);
    checkOutput("midrst_bus_levels", bus3(), 3'b101);
    checkOutput("midrst_bus_sel", bus_if.bus_sel, 0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    checkOutput("postrst_both_grant_a", bus_if.grant_a, 1);
    checkOutput("postrst_both_grant_u", bus_if.grant_u, 0);

    // A releases with U pending: 16 idle guard cycles, IDLE, then U
    applyStimulus(1'b0, 1'b1);
    waitGrant(1'b1, 40, edges, bad);
    checkOutput("a_to_u_edges", edges, 18);
    checkOutput("a_to_u_idle_bus", bad, 0);

    // Round-robin: A waits for U, then U wins after A although both request
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    checkOutput("no_preempt_u", bus_if.grant_u, 1);
    applyStimulus(1'b1, 1'b0);
    waitGrant(1'b0, 40, edges, bad);
    checkOutput("u_to_a_edges", edges, 18);
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b1);
    waitGrant(1'b1, 40, edges, bad);
    checkOutput("rr_u_after_a_edges", edges, 17);
    checkOutput("rr_u_after_a_grant_a", bus_if.grant_a, 0);
    applyStimulus(1'b1, 1'b0);
    waitGrant(1'b0, 40, edges, bad);
    checkOutput("rr_a_after_u_edges", edges, 18);
    applyStimulus(1'b0, 1'b0);
    repeat (GUARD + 4) stepCycle();

    // Ownership timeout of 100 cycles with req_a held
    timeout_cycles = 32'd100;
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("to_grant_a", bus_if.grant_a, 1);
`ifdef SDSPI_ARB_TIMEOUT_EN
    owned = 1;
    pulses = 0;
    for (int i = 0; i < 300 && bus_if.grant_a; i++) begin
      stepCycle();
      if (bus_if.grant_a) owned++;
      if (timeout_err) pulses++;
    end
    err_at_fall = timeout_err;
    checkOutput("to_owned_cycles", owned, 100);
    checkOutput("to_err_at_fall", err_at_fall, 1);
    regrant = 0;
    repeat (40) begin
      stepCycle();
      if (bus_if.grant_a) regrant++;
      if (timeout_err) pulses++;
    end
    checkOutput("to_err_pulses", pulses, 1);
    checkOutput("to_no_regrant_held", regrant, 0);
    checkOutput("to_sticky", timeout_sticky, 1);
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("to_regrant_after_toggle", bus_if.grant_a, 1);
`else
    lost = 0;
    repeat (150) begin
      stepCycle();
      if (!bus_if.grant_a || timeout_err) lost++;
    end
    checkOutput("to_disabled_hold", lost, 0);
    checkOutput("to_disabled_sticky", timeout_sticky, 0);
`endif
    timeout_cycles = '0;

    // A was served last; reset must restore A priority for a contended request
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    checkOutput("rst2_grant_a_low", bus_if.grant_a, 0);
    checkOutput("rst2_sticky_clear", timeout_sticky, 0);
    rst = 1'b1;
    stepCycle();
    checkOutput("rst_favours_a", bus_if.grant_a, 1);
    checkOutput("rst_favours_a_u_low", bus_if.grant_u, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
